uart_tx: RTL and testbench
==========================

# uart_tx

Serial UART transmitter that feeds the line decoded by the team's `Rx` receiver. It runs on the same 16x oversampling baud clock (`bd_rate_gen`). It accepts one parallel character per handshake and serialises it as a frame: start bit, 7 or 8 data bits LSB first, optional even/odd parity, and 1 or 2 stop bits. Its frame-format inputs use the same encoding as the receiver, so one configuration drives both ends of a link.

## Interface
- `OVERSAMPLE`, 16: `bd_rate_gen` cycles per serial bit; must be a power of two ≥ 2.
- `bd_rate_gen`  input  1  clock (16x baud tick); all logic on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `data_in`  input  8  character to send; bit 7 ignored when `d_num`=0.
- `tx_start`  input  1  load request; level-sampled, acted on only when `busy`=0.
- `d_num`  input  1  data length: 0 = 7 bits, 1 = 8 bits.
- `par`  input  2  parity: 00 none, 01 even (bit = XOR of data), 10 odd (bit = ~XOR of data), 11 none.
- `s_num`  input  1  stop bits: 0 = one, 1 = two.
- `tx`  output  1  serial line; idle/mark = 1.
- `busy`  output  1  high while a frame is in progress.
- `done`  output  1  one-cycle pulse at frame completion.

## Operation
- Reset: `tx`=1, `busy`=0, `done`=0, state IDLE, all counters and the shift register cleared.
- States: IDLE → START → DATA → PARITY → STOP → IDLE.
- PARITY is skipped when `par` is 00 or 11.
- **Accept:** in IDLE with `tx_start`=1 the block:
  - latches `data_in`, `d_num`, `par` and `s_num` into internal registers;
  - computes the parity bit from the latched data (7 or 8 bits per `d_num`);
  - enters START.
- Inputs are don't-care for the rest of the frame. Changing them mid-frame has no effect.
- Each bit holds `tx` for exactly `OVERSAMPLE` cycles, timed by a `log2(OVERSAMPLE)`-bit tick counter that wraps 15→0 and advances the state or bit on wrap.
- DATA shifts the latched word right, LSB first. It ends after bit 6 (`d_num`=0) or bit 7 (`d_num`=1), using a 3-bit index.
- STOP drives 1 for one bit period (`s_num`=0) or two (`s_num`=1).
- `tx_start` while `busy`=1 is ignored. It is not queued.
- `reset` asserted mid-frame abandons the frame at the next edge: all outputs return to reset values and no `done` pulse is produced.
- The parity bit is a registered copy computed at accept. It is never recomputed mid-frame.

## Timing
- Frame length `F` = 1 + (7|8) + (0|1) + (1|2) bits. Frame duration is `OVERSAMPLE`·`F` cycles.
- Accept at edge k:
  - after edge k, `tx`=0 (start bit) and `busy`=1;
  - data bit i appears after edge k+16·(1+i).
- After edge k+16·F:
  - `busy`=0 and `done`=1 for exactly one cycle;
  - `tx` is already 1 (stop level continues as idle).
- Earliest next accept is edge k+16·F+1, giving one idle cycle minimum between frames.
- Back-to-back operation is legal with `tx_start` held high: frames repeat every 16·F+1 cycles.
- `tx` is driven directly from a flop, with no combinational path from inputs to `tx`.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - parity encodings `PAR_NONE`=2'b00, `PAR_EVEN`=2'b01, `PAR_ODD`=2'b10;
  - the default `OVERSAMPLE`;
  - a parity function taking data and length.
- Single module, no sub-modules. The tick counter is too small to justify one.

## Test plan
- **8N1, `data_in`=0xA5** → `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit held 16 cycles; `done` pulses 160 cycles after accept; `busy` high for exactly 160 cycles.
- **7E2, `data_in`=0x41** → 0,1,0,0,0,0,0,1,0(parity),1,1; 176 cycles. Then repeat with `par`=10 (odd) → parity bit = 1.
- **8O1, `data_in`=0x00** → parity bit 1; 8E1 with 0xFF → parity bit 0; `par`=11 behaves identically to 00 (10-bit frame).
- **`tx_start` pulsed at cycle 40 of a frame with different `data_in`** → current frame bit-exact and unchanged; no second frame starts. With `tx_start` held continuously → frames separated by exactly one idle cycle.
- **`reset` at cycle 70 of an 8N1 frame** → next edge `tx`=1, `busy`=0, no `done`. A new `tx_start` afterward produces a clean full frame.
- **Loopback `tx` → `Rx` serial input** with matching `d_num`/`par`/`s_num`, 256 random characters across all formats → `Rx` `data_out` equals the sent data and `err`=0 whenever parity is enabled.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-state encoding, parity codes, default oversampling.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package uart_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // XOR of the character bits that are actually sent (7 or 8 of them).
  function automatic logic data_parity(input logic [7:0] data, input logic d_num);
    return d_num ? (^data) : (^data[6:0]);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Parallel-side bundle of the UART transmitter: character, frame format, line and status.
// Latency: n/a (wires only).
// Backpressure: tx_start is only honoured while busy is low; no queueing.
interface uart_tx_if;
  logic [7:0] data_in;
  logic       tx_start;
  logic       d_num;
  logic [1:0] par;
  logic       s_num;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (
    output data_in, tx_start, d_num, par, s_num,
    input  tx, busy, done
  );

  modport slave (
    input  data_in, tx_start, d_num, par, s_num,
    output tx, busy, done
  );
endinterface

// File: rtl/uart_tx.sv
// Serialises one character per accept as start, 7/8 data LSB first, optional parity, 1/2 stop bits.
// Latency: tx drops to the start bit on the accept edge; done pulses OVERSAMPLE*F cycles later.
// Backpressure: busy stays high for the whole frame; tx_start seen while busy is dropped.
module uart_tx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
)
(
  input logic     bd_rate_gen,
  input logic     reset,
  uart_tx_if.slave io
);

  localparam int TW = $clog2(OVERSAMPLE);

  tx_state_t       state, state_nxt;
  logic [TW-1:0]   tick, tick_nxt;
  logic [2:0]      bit_idx, bit_idx_nxt;
  logic            stop_idx, stop_idx_nxt;
  logic [7:0]      shreg, shreg_nxt;
  logic            d_num_r, d_num_nxt;
  logic [1:0]      par_r, par_nxt;
  logic            s_num_r, s_num_nxt;
  logic            par_bit, par_bit_nxt;
  logic            tx_r, tx_nxt;
  logic            busy_r, busy_nxt;
  logic            done_r, done_nxt;

  logic            tick_wrap;
  logic            par_on;

  assign tick_wrap = (tick == '1);
  assign par_on    = (par_r == PAR_EVEN) || (par_r == PAR_ODD);

  // Next-state and next-output decode; tx is computed here but only ever leaves through a flop.
  always_comb begin
    state_nxt    = state;
    tick_nxt     = tick;
    bit_idx_nxt  = bit_idx;
    stop_idx_nxt = stop_idx;
    shreg_nxt    = shreg;
    d_num_nxt    = d_num_r;
    par_nxt      = par_r;
    s_num_nxt    = s_num_r;
    par_bit_nxt  = par_bit;
    tx_nxt       = tx_r;
    busy_nxt     = busy_r;
    done_nxt     = 1'b0;

    if (state != IDLE) begin
      tick_nxt = tick + TW'(1);
    end

    case (state)
      IDLE: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
        tick_nxt = '0;
        if (io.tx_start) begin
          shreg_nxt   = io.data_in;
          d_num_nxt   = io.d_num;
          par_nxt     = io.par;
          s_num_nxt   = io.s_num;
          // Odd parity is the complement of the data XOR; frozen here for the whole frame.
          par_bit_nxt = data_parity(io.data_in, io.d_num) ^ (io.par == PAR_ODD);
          state_nxt   = START;
          tx_nxt      = 1'b0;
          busy_nxt    = 1'b1;
        end
      end

      START: begin
        if (tick_wrap) begin
          state_nxt   = DATA;
          bit_idx_nxt = 3'd0;
          tx_nxt      = shreg[0];
        end
      end

      DATA: begin
        if (tick_wrap) begin
          // Last index is 6 for 7-bit characters and 7 for 8-bit ones.
          if (bit_idx == {2'b11, d_num_r}) begin
            if (par_on) begin
              state_nxt = PARITY;
              tx_nxt    = par_bit;
            end else begin
              state_nxt    = STOP;
              stop_idx_nxt = 1'b0;
              tx_nxt       = 1'b1;
            end
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
            shreg_nxt   = {1'b0, shreg[7:1]};
            tx_nxt      = shreg[1];
          end
        end
      end

      PARITY: begin
        if (tick_wrap) begin
          state_nxt    = STOP;
          stop_idx_nxt = 1'b0;
          tx_nxt       = 1'b1;
        end
      end

      STOP: begin
        if (tick_wrap) begin
          if (s_num_r && !stop_idx) begin
            stop_idx_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            tx_nxt    = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, counters, latched frame format and output flops; reset abandons any frame in flight.
  always_ff @(posedge bd_rate_gen) begin
    if (reset) begin
      state    <= IDLE;
      tick     <= '0;
      bit_idx  <= 3'd0;
      stop_idx <= 1'b0;
      shreg    <= 8'd0;
      d_num_r  <= 1'b0;
      par_r    <= PAR_NONE;
      s_num_r  <= 1'b0;
      par_bit  <= 1'b0;
      tx_r     <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick     <= tick_nxt;
      bit_idx  <= bit_idx_nxt;
      stop_idx <= stop_idx_nxt;
      shreg    <= shreg_nxt;
      d_num_r  <= d_num_nxt;
      par_r    <= par_nxt;
      s_num_r  <= s_num_nxt;
      par_bit  <= par_bit_nxt;
      tx_r     <= tx_nxt;
      busy_r   <= busy_nxt;
      done_r   <= done_nxt;
    end
  end

  assign io.tx   = tx_r;
  assign io.busy = busy_r;
  assign io.done = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed frame formats plus random loopback against a bit-list frame model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx;

  logic bd_rate_gen = 1'b0;
  logic reset;

  uart_tx_if bus();

  uart_tx #(.OVERSAMPLE(16)) dut (
    .bd_rate_gen (bd_rate_gen),
    .reset       (reset),
    .io          (bus.slave)
  );

  always #5 bd_rate_gen = ~bd_rate_gen;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: observed %0h required %0h", tag, obs, exp_v);
  endtask

  // Drives one accept at the next rising edge and follows the frame cycle by cycle.
  // Expected line: a list of bits built from the frame rules, each held 16 cycles.
  task automatic send_frame(
    input  logic [7:0]  data,
    input  logic        dn,
    input  logic [1:0]  pr,
    input  logic        sn,
    input  bit          hold,
    input  int          pulse_at,
    input  int          abort_at,
    output int          busy_cycles,
    output logic [11:0] bits_obs
  );
    logic       exp_bits[$];
    logic [7:0] mask;
    logic [7:0] rx_data;
    logic       exp_tx, exp_busy, exp_done, par_obs, err;
    bit         par_on;
    int         nbits, fcyc, errs, ndata, done_seen, busy_seen;

    mask   = dn ? 8'hFF : 8'h7F;
    ndata  = dn ? 8 : 7;
    par_on = (pr == 2'b01) || (pr == 2'b10);
    exp_bits = {};
    exp_bits.push_back(1'b0);
    for (int i = 0; i < ndata; i++) exp_bits.push_back(data[i]);
    if (par_on) exp_bits.push_back((^(data & mask)) ^ (pr == 2'b10));
    exp_bits.push_back(1'b1);
    if (sn) exp_bits.push_back(1'b1);
    nbits = exp_bits.size();
    fcyc  = 16 * nbits;

    busy_cycles = 0;
    bits_obs    = '0;
    errs        = 0;

    bus.data_in  = data;
    bus.d_num    = dn;
    bus.par      = pr;
    bus.s_num    = sn;
    bus.tx_start = 1'b1;
    @(posedge bd_rate_gen);

    for (int c = 0; c <= fcyc; c++) begin
      @(negedge bd_rate_gen);
      if (c < fcyc) begin
        exp_tx = exp_bits[c / 16]; exp_busy = 1'b1; exp_done = 1'b0;
      end else begin
        exp_tx = 1'b1; exp_busy = 1'b0; exp_done = 1'b1;
      end
      if (bus.tx !== exp_tx || bus.busy !== exp_busy || bus.done !== exp_done) errs++;
      if (bus.busy === 1'b1) busy_cycles++;
      if (c < fcyc && (c % 16) == 8) bits_obs[c / 16] = bus.tx;

      if (c == 0) begin
        // Inputs are don't-care once the frame is running.
        bus.data_in = 8'($urandom);
        bus.d_num   = 1'($urandom);
        bus.par     = 2'($urandom);
        bus.s_num   = 1'($urandom);
        if (!hold) bus.tx_start = 1'b0;
      end
      if (pulse_at > 0 && c == pulse_at) begin
        bus.data_in  = ~data;
        bus.tx_start = 1'b1;
      end
      if (pulse_at > 0 && c == pulse_at + 1) bus.tx_start = 1'b0;

      if (abort_at > 0 && c == abort_at - 1) begin
        chk("pre_abort_wave", 32'(errs), 32'd0);
        reset = 1'b1;
        @(negedge bd_rate_gen);
        chk("abort_tx", 32'(bus.tx), 32'd1);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        done_seen = 0;
        busy_seen = 0;
        for (int q = 0; q < 200; q++) begin
          @(negedge bd_rate_gen);
          if (bus.done === 1'b1) done_seen++;
          if (bus.busy === 1'b1) busy_seen++;
        end
        chk("abort_no_done", 32'(done_seen), 32'd0);
        chk("abort_idle", 32'(busy_seen), 32'd0);
        return;
      end
    end

    chk("wave", 32'(errs), 32'd0);
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("busy_len", 32'(busy_cycles), 32'(fcyc));

    // Mid-bit decode of the observed line, as a receiver would see it.
    rx_data = '0;
    for (int i = 0; i < ndata; i++) rx_data[i] = bits_obs[1 + i];
    chk("rx_start", 32'(bits_obs[0]), 32'd0);
    chk("rx_data", 32'(rx_data), 32'(data & mask));
    if (par_on) begin
      par_obs = bits_obs[1 + ndata];
      err = par_obs ^ (^rx_data) ^ (pr == 2'b10);
      chk("rx_err", 32'(err), 32'd0);
    end
    chk("rx_stop", 32'(bits_obs[nbits - 1]), 32'd1);

    if (!hold) bus.tx_start = 1'b0;
    if (pulse_at > 0) begin
      @(negedge bd_rate_gen);
      chk("no_requeue_busy", 32'(bus.busy), 32'd0);
      chk("no_requeue_tx", 32'(bus.tx), 32'd1);
    end
  endtask

  initial begin
    int          bc;
    logic [11:0] bo;
    logic [7:0]  rd;
    logic        rdn, rsn;
    logic [1:0]  rpr;

    reset        = 1'b1;
    bus.tx_start = 1'b0;
    bus.data_in  = 8'h00;
    bus.d_num    = 1'b1;
    bus.par      = 2'b00;
    bus.s_num    = 1'b0;
    repeat (3) @(posedge bd_rate_gen);
    @(negedge bd_rate_gen);
    chk("reset_tx", 32'(bus.tx), 32'd1);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge bd_rate_gen);
    chk("idle_tx", 32'(bus.tx), 32'd1);

    // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
    send_frame(8'hA5, 1'b1, 2'b00, 1'b0, 0, 0, 0, bc, bo);
    chk("8N1_bits", 32'(bo), 32'h34A);
    chk("8N1_len", 32'(bc), 32'd160);

    // 7E2 0x41: 0,1,0,0,0,0,0,1,0,1,1 then odd parity flips the parity bit
    send_frame(8'h41, 1'b0, 2'b01, 1'b1, 0, 0, 0, bc, bo);
    chk("7E2_bits", 32'(bo), 32'h682);
    chk("7E2_len", 32'(bc), 32'd176);
    send_frame(8'h41, 1'b0, 2'b10, 1'b1, 0, 0, 0, bc, bo);
    chk("7O2_bits", 32'(bo), 32'h782);

    send_frame(8'h00, 1'b1, 2'b10, 1'b0, 0, 0, 0, bc, bo);
    chk("8O1_par", 32'(bo[9]), 32'd1);
    chk("8O1_len", 32'(bc), 32'd176);
    send_frame(8'hFF, 1'b1, 2'b01, 1'b0, 0, 0, 0, bc, bo);
    chk("8E1_par", 32'(bo[9]), 32'd0);

    // par=11 must look exactly like no parity
    send_frame(8'h5A, 1'b1, 2'b00, 1'b0, 0, 0, 0, bc, bo);
    chk("8N1_5A_bits", 32'(bo), 32'h2B4);
    send_frame(8'h5A, 1'b1, 2'b11, 1'b0, 0, 0, 0, bc, bo);
    chk("par11_bits", 32'(bo), 32'h2B4);
    chk("par11_len", 32'(bc), 32'd160);

    // Start request mid-frame with other data is ignored, not queued
    send_frame(8'h3C, 1'b1, 2'b00, 1'b0, 0, 40, 0, bc, bo);

    // tx_start held high: next frame accepted on the edge right after done
    send_frame(8'h12, 1'b1, 2'b00, 1'b0, 1, 0, 0, bc, bo);
    send_frame(8'h34, 1'b1, 2'b01, 1'b1, 1, 0, 0, bc, bo);
    send_frame(8'h56, 1'b0, 2'b00, 1'b0, 0, 0, 0, bc, bo);

    // Reset at cycle 70 of an 8N1 frame, then a clean frame
    send_frame(8'h99, 1'b1, 2'b00, 1'b0, 0, 0, 70, bc, bo);
    send_frame(8'hC3, 1'b1, 2'b00, 1'b0, 0, 0, 0, bc, bo);
    chk("post_reset_len", 32'(bc), 32'd160);

    // Random characters across all formats with short random idle gaps
    for (int n = 0; n < 256; n++) begin
      rd  = 8'($urandom);
      rdn = 1'($urandom);
      rpr = 2'($urandom);
      rsn = 1'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge bd_rate_gen);
      send_frame(rd, rdn, rpr, rsn, 0, 0, 0, bc, bo);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
